// File: rtl/core_pkg.sv
// core_pkg -- definitions shared by the fetch stage and the decoder.
//   fetch_state_t : fetch FSM state encoding.
//   NOP_INSTR     : addi x0,x0,0. Presented to the decoder when no
//                   instruction is held.
package core_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if -- instruction-memory read handshake.
//   imem_req    : fetch -> memory, read request
//   imem_addr   : fetch -> memory, word address (bits [1:0] are 0)
//   imem_ready  : memory -> fetch, request accepted when req && ready
//   imem_rvalid : memory -> fetch, read data valid
//   imem_rdata  : memory -> fetch, read data
// master = fetch stage, slave = instruction memory.
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction-fetch stage. It owns the PC and issues one
// word read at a time. It holds the fetched word and its PC until the
// decoder takes them. It applies branch redirects and drops any fetch
// that a redirect has made stale.
// Ports:
//   CLK, RST_n    : clock, synchronous active-low reset
//   imem          : instruction-memory handshake (master side)
//   branch_taken  : single-cycle redirect pulse from execute
//   branch_target : redirect PC (bits [1:0] are forced to 0)
//   stall         : decoder cannot accept the held instruction
//   instr_out     : instruction to the decoder (NOP_INSTR when not valid)
//   pc_out        : PC of instr_out
//   instr_valid   : instr_out/pc_out hold a fetched instruction
// All outputs decode from registered state only.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  instr_fetch_if.master        imem,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 stall,
  output logic [31:0]          instr_out,
  output logic [31:0]          pc_out,
  output logic                 instr_valid
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  instr_reg, instr_next;
  logic         redirect_pend_reg, redirect_pend_next;
  logic [31:0]  redirect_pc_reg, redirect_pc_next;

  // Word-aligned redirect target. The mask keeps every input bit in use.
  logic [31:0] target;
  assign target = branch_target & ~32'h0000_0003;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    instr_next         = instr_reg;
    redirect_pend_next = redirect_pend_reg;
    redirect_pc_next   = redirect_pc_reg;

    case (state_reg)
      S_IDLE: begin
        if (branch_taken) pc_next = target;
        state_next = S_REQ;
      end

      S_REQ: begin
        if (branch_taken) begin
          pc_next = target;
          // The old address was accepted in this same cycle. Its response
          // is now stale, so remember where to go once it arrives.
          if (imem.imem_ready) begin
            redirect_pend_next = 1'b1;
            redirect_pc_next   = target;
            state_next         = S_WAIT;
          end
        end else if (imem.imem_ready) begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (branch_taken) begin
            pc_next            = target;
            redirect_pend_next = 1'b0;
            state_next         = S_REQ;
          end else if (redirect_pend_reg) begin
            pc_next            = redirect_pc_reg;
            redirect_pend_next = 1'b0;
            state_next         = S_REQ;
          end else begin
            instr_next = imem.imem_rdata;
            state_next = S_HOLD;
          end
        end else if (branch_taken) begin
          // A later branch overwrites the pending target.
          redirect_pend_next = 1'b1;
          redirect_pc_next   = target;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_next    = target;
          state_next = S_REQ;
        end else if (!stall) begin
          pc_next    = pc_reg + 32'd4;  // wraps modulo 2^32
          state_next = S_REQ;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_reg         <= S_IDLE;
      pc_reg            <= RESET_PC;
      instr_reg         <= NOP_INSTR;
      redirect_pend_reg <= 1'b0;
      redirect_pc_reg   <= RESET_PC;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      instr_reg         <= instr_next;
      redirect_pend_reg <= redirect_pend_next;
      redirect_pc_reg   <= redirect_pc_next;
    end
  end

  assign imem.imem_req  = (state_reg == S_REQ);
  assign imem.imem_addr = pc_reg;
  assign instr_valid    = (state_reg == S_HOLD);
  assign instr_out      = instr_valid ? instr_reg : NOP_INSTR;
  assign pc_out         = pc_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. Inputs are driven and outputs are
// checked 1 time unit after each rising edge.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;

  int errors = 0;
  int checks = 0;

  instr_fetch_if imem ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .imem          (imem),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Call while in S_REQ: accept the request, then return data on the next cycle.
  task automatic fetch(input logic [31:0] data);
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = data;
    tick();
    imem.imem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   {31'd0, imem.imem_req}, 32'd0);
    check({tag, ".addr"},  imem.imem_addr, 32'h0);
    check({tag, ".pc"},    pc_out, 32'h0);
    check({tag, ".instr"}, instr_out, NOP);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;

    // Reset.
    tick(); tick();
    check_reset_outputs("rst");

    // Zero-wait fetches from 0x0 and 0x4.
    RST_n = 1'b1;
    tick();                                         // cycle 1
    check("c1.req",  {31'd0, imem.imem_req}, 32'd1);
    check("c1.addr", imem.imem_addr, 32'h0);
    fetch(32'h0000_0033);                           // cycle 3
    check("c3.valid", {31'd0, instr_valid}, 32'd1);
    check("c3.pc",    pc_out, 32'h0);
    check("c3.instr", instr_out, 32'h0000_0033);
    tick();
    check("i1.addr", imem.imem_addr, 32'h4);
    fetch(32'h0040_0093);
    check("i1.pc",    pc_out, 32'h4);
    check("i1.instr", instr_out, 32'h0040_0093);

    // Stall for 5 cycles in S_HOLD.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d.instr", i), instr_out, 32'h0040_0093);
      check($sformatf("stall%0d.pc", i), pc_out, 32'h4);
      check($sformatf("stall%0d.valid", i), {31'd0, instr_valid}, 32'd1);
      check($sformatf("stall%0d.req", i), {31'd0, imem.imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("unstall.req",  {31'd0, imem.imem_req}, 32'd1);
    check("unstall.addr", imem.imem_addr, 32'h8);

    // Branch during S_WAIT; the response comes 3 cycles later and is dropped.
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    tick();
    check("bw.valid1", {31'd0, instr_valid}, 32'd0);
    check("bw.req1",   {31'd0, imem.imem_req}, 32'd0);
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem.imem_rvalid = 1'b0;
    check("bw.valid", {31'd0, instr_valid}, 32'd0);
    check("bw.req",   {31'd0, imem.imem_req}, 32'd1);
    check("bw.addr",  imem.imem_addr, 32'h0000_0100);
    fetch(32'h0000_0011);
    check("bw.pc",    pc_out, 32'h0000_0100);
    check("bw.instr", instr_out, 32'h0000_0011);

    // Branch together with stall in S_HOLD.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    check("bh.valid", {31'd0, instr_valid}, 32'd0);
    check("bh.instr", instr_out, NOP);
    check("bh.req",   {31'd0, imem.imem_req}, 32'd1);
    check("bh.addr",  imem.imem_addr, 32'h0000_0200);

    // Branch in the same cycle as rvalid.
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h1234_5678;
    branch_taken = 1'b1; branch_target = 32'h0000_0300;
    tick();
    imem.imem_rvalid = 1'b0; branch_taken = 1'b0;
    check("br.valid", {31'd0, instr_valid}, 32'd0);
    check("br.req",   {31'd0, imem.imem_req}, 32'd1);
    check("br.addr",  imem.imem_addr, 32'h0000_0300);

    // Branch in S_REQ, not accepted: the address changes immediately.
    branch_taken = 1'b1; branch_target = 32'h0000_0404;
    tick();
    branch_taken = 1'b0;
    check("bq.req",  {31'd0, imem.imem_req}, 32'd1);
    check("bq.addr", imem.imem_addr, 32'h0000_0404);

    // Branch in S_REQ with acceptance in the same cycle: the old response is stale.
    imem.imem_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_0500;
    tick();
    imem.imem_ready = 1'b0; branch_taken = 1'b0;
    check("ba.req", {31'd0, imem.imem_req}, 32'd0);
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem.imem_rvalid = 1'b0;
    check("ba.valid", {31'd0, instr_valid}, 32'd0);
    check("ba.addr",  imem.imem_addr, 32'h0000_0500);

    // PC wrap at 0xFFFF_FFFC; low target bits are ignored.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    check("wr.addr", imem.imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0077);
    check("wr.pc", pc_out, 32'hFFFF_FFFC);
    tick();
    check("wr.next", imem.imem_addr, 32'h0000_0000);

    // Reset during S_WAIT, then a spurious rvalid in S_IDLE.
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    RST_n = 1'b0;
    tick();
    check_reset_outputs("rw");
    RST_n = 1'b1;
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0BAD_0BAD;
    tick();
    imem.imem_rvalid = 1'b0;
    check("rs.valid", {31'd0, instr_valid}, 32'd0);
    check("rs.req",   {31'd0, imem.imem_req}, 32'd1);
    check("rs.addr",  imem.imem_addr, 32'h0);
    fetch(32'h0000_0033);
    check("rs.pc",    pc_out, 32'h0);
    check("rs.instr", instr_out, 32'h0000_0033);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RISC-V core, directly upstream of the instruction decoder/control unit. Owns the program counter and issues one word read at a time to instruction memory over a request/response handshake. Holds each fetched word and its PC stable until the decoder accepts it. Applies branch redirects from the execute stage and discards any fetch that a redirect makes stale.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, word driven on instr_out when no valid instruction is held (addi x0,x0,0).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_n  in  1  synchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_ready  in  1  memory accepts the request this cycle (req && ready = accepted).
- imem_rvalid  in  1  read data valid; at most one response per accepted request, ≥1 cycle after acceptance.
- imem_rdata  in  32  read data, sampled only when imem_rvalid = 1.
- branch_taken  in  1  single-cycle redirect pulse from execute.
- branch_target  in  32  redirect PC; bits [1:0] ignored and treated as 0.
- stall  in  1  decoder cannot accept the held instruction this cycle.
- instr_out  out  32  instruction presented to the decoder.
- pc_out  out  32  PC of instr_out.
- instr_valid  out  1  instr_out/pc_out hold a valid fetched instruction.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Registers: pc, instr, state, redirect_pend, redirect_pc.
- S_IDLE: entered on reset; next cycle → S_REQ with imem_addr = pc.
- S_REQ: imem_req = 1, imem_addr = pc. On accept → S_WAIT. imem_addr is stable while unaccepted.
- S_WAIT: imem_req = 0. On imem_rvalid: if redirect_pend (or branch_taken in the same cycle), drop data, pc ← redirect target, clear redirect_pend → S_REQ. Otherwise instr ← imem_rdata → S_HOLD.
- S_HOLD: instr_valid = 1. If branch_taken: drop instr, pc ← target → S_REQ. Else if !stall: instruction consumed, pc ← pc + 4 → S_REQ. Else stay; instr_out and pc_out unchanged.
- branch_taken in S_REQ (request not yet accepted): pc and imem_addr ← target immediately, stay in S_REQ. If the request is accepted in that same cycle, the old address was accepted: set redirect_pend and redirect_pc → S_WAIT.
- branch_taken in S_WAIT: set redirect_pend and redirect_pc; a later branch_taken overwrites redirect_pc.
- branch_taken in S_IDLE: pc ← target.
- Arithmetic: pc + 4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- imem_rvalid outside S_WAIT is ignored. Instruction memory shares RST_n, so no response survives reset.
- instr_out = NOP_INSTR whenever instr_valid = 0.

## Timing
- Reset (RST_n sampled low): state = S_IDLE, pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC, pc_out = RESET_PC, instr_out = NOP_INSTR, instr_valid = 0, redirect_pend = 0. Reset overrides any in-flight state.
- imem_req, imem_addr, instr_out, pc_out, and instr_valid are decoded from registered state only. No input reaches an output combinationally.
- Zero-wait memory (ready in S_REQ, rvalid the next cycle): S_REQ → S_WAIT → S_HOLD. instr_valid rises 2 cycles after request acceptance.
- Throughput without stall: 1 instruction per 3 cycles.
- After release from reset: first imem_req at cycle 1; first instr_valid at cycle 3 with zero-wait memory.
- Priority in one cycle: RST_n > branch_taken > imem_rvalid > stall.

## Structure
- Package core_pkg: fetch_state_t enum (S_IDLE, S_REQ, S_WAIT, S_HOLD) and the NOP_INSTR constant shared with the decoder.
- Single module; the next-PC mux is inline. No sub-module.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0033 at 0x0, 32'h0040_0093 at 0x4 → imem_addr 0x0 at cycle 1, instr_valid at cycle 3 with pc_out 0x0 and instr 0x0000_0033, next instruction at pc_out 0x4.
- stall held 5 cycles in S_HOLD → instr_out, pc_out, and instr_valid unchanged for 5 cycles, no imem_req; release → request to pc + 4.
- branch_taken with target 0x0000_0103 during S_WAIT, rvalid 3 cycles later → data dropped, instr_valid stays 0, next imem_addr = 0x0000_0100.
- branch_taken together with stall in S_HOLD → instruction dropped, next request to target; branch_taken in the same cycle imem_rvalid arrives → data dropped.
- pc = 0xFFFF_FFFC consumed → next imem_addr = 0x0000_0000.
- RST_n low during S_WAIT, with a spurious rvalid during S_IDLE → all outputs at reset values, rvalid ignored, fetch restarts from RESET_PC.
